// File: rtl/game_controller.sv
// Stickman-runner sequencer: start/death/restart FSM, BCD score, high score and difficulty level.
// State moves one Clk after each frame tick; presses and collisions are latched between ticks; no backpressure.
module game_controller #(
  parameter int unsigned SCORE_DIV    = 6,
  parameter int unsigned LEVEL_FRAMES = 600,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned BASE_SPEED   = 2,
  parameter int unsigned FLASH_FRAMES = 30,
  parameter logic [7:0]  START_KEY    = 8'h2C
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        is_stickman,
  input  logic        is_obstacle,
  output logic        playing,
  output logic        dying,
  output logic        game_over,
  output logic        flash,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [3:0]  level,
  output logic [4:0]  speed
);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_DYING, S_OVER} state_e;

  localparam logic [7:0]  SCORE_LAST = 8'(SCORE_DIV - 1);
  localparam logic [9:0]  LVL_LAST   = 10'(LEVEL_FRAMES - 1);
  localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [3:0]  LVL_MAX    = 4'(MAX_LEVEL);
  localparam logic [4:0]  SPD_BASE   = 5'(BASE_SPEED);
  localparam logic [15:0] SCORE_MAX  = 16'h9999;

  state_e      state_q;
  logic        frame_clk_q;
  logic        frame_tick_q;
  logic        key_q;
  logic        press_pend_q;
  logic        press_pend_d;
  logic        hit_pend_q;
  logic        hit_pend_d;
  logic        key_hit;
  logic        press;
  logic        collide;
  logic        hit;
  logic        playing_q;
  logic        dying_q;
  logic        over_q;
  logic        flash_q;
  logic [15:0] score_q;
  logic [15:0] high_q;
  logic [15:0] score_inc;
  logic [3:0]  level_q;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  flash_cnt_q;
  logic [7:0]  flash_cnt_inc;
  logic [9:0]  lvl_cnt_q;

  // Ripple a +1 through four BCD digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign key_hit       = (keycode == START_KEY);
  assign press         = key_hit & ~key_q;
  assign collide       = is_stickman & is_obstacle;
  assign hit           = hit_pend_q | collide;
  assign press_pend_d  = frame_tick_q ? 1'b0 : (press_pend_q | press);
  assign hit_pend_d    = frame_tick_q ? 1'b0 : (hit_pend_q | ((state_q == S_PLAYING) & collide));
  assign score_inc     = (score_q == SCORE_MAX) ? score_q : bcd_inc(score_q);
  assign flash_cnt_inc = flash_cnt_q + 8'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      key_q        <= 1'b0;
      press_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
    end else begin
      frame_clk_q  <= frame_clk;
      frame_tick_q <= frame_clk & ~frame_clk_q;
      key_q        <= key_hit;
      press_pend_q <= press_pend_d;
      hit_pend_q   <= hit_pend_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      playing_q   <= 1'b0;
      dying_q     <= 1'b0;
      over_q      <= 1'b0;
      flash_q     <= 1'b0;
      score_q     <= 16'h0000;
      high_q      <= 16'h0000;
      level_q     <= 4'd0;
      frame_cnt_q <= 8'd0;
      lvl_cnt_q   <= 10'd0;
      flash_cnt_q <= 8'd0;
    end else if (frame_tick_q) begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (press_pend_q) begin
            state_q     <= S_PLAYING;
            playing_q   <= 1'b1;
            over_q      <= 1'b0;
            flash_q     <= 1'b0;
            score_q     <= 16'h0000;
            level_q     <= 4'd0;
            frame_cnt_q <= 8'd0;
            lvl_cnt_q   <= 10'd0;
            flash_cnt_q <= 8'd0;
          end
        end
        S_PLAYING: begin
          if (hit) begin
            state_q     <= S_DYING;
            playing_q   <= 1'b0;
            dying_q     <= 1'b1;
            flash_q     <= 1'b0;
            flash_cnt_q <= 8'd0;
          end else begin
            if (frame_cnt_q == SCORE_LAST) begin
              frame_cnt_q <= 8'd0;
              score_q     <= score_inc;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (lvl_cnt_q == LVL_LAST) begin
              lvl_cnt_q <= 10'd0;
              if (level_q < LVL_MAX) level_q <= level_q + 4'd1;
            end else begin
              lvl_cnt_q <= lvl_cnt_q + 10'd1;
            end
          end
        end
        S_DYING: begin
          if (flash_cnt_q == FLASH_LAST) begin
            state_q <= S_OVER;
            dying_q <= 1'b0;
            over_q  <= 1'b1;
            flash_q <= 1'b0;
            // BCD digits order the same way as binary, so a plain compare works.
            if (score_q > high_q) high_q <= score_q;
          end else begin
            flash_cnt_q <= flash_cnt_inc;
            flash_q     <= flash_cnt_inc[2];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign playing    = playing_q;
  assign dying      = dying_q;
  assign game_over  = over_q;
  assign flash      = flash_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign level      = level_q;
  assign speed      = SPD_BASE + {1'b0, level_q};

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus a randomized run against an event-level game model.
module tb_game_controller;

  localparam int SCORE_DIV    = 6;
  localparam int LEVEL_FRAMES = 600;
  localparam int MAX_LEVEL    = 7;
  localparam int BASE_SPEED   = 2;
  localparam int FLASH_FRAMES = 30;
  localparam logic [7:0] START_KEY = 8'h2C;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic        is_stickman = 1'b0;
  logic        is_obstacle = 1'b0;
  logic        playing, dying, game_over, flash;
  logic [15:0] score, high_score;
  logic [3:0]  level;
  logic [4:0]  speed;
  logic        s_playing, s_dying, s_game_over, s_flash;
  logic [15:0] s_score, s_high_score;
  logic [3:0]  s_level;
  logic [4:0]  s_speed;

  game_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .is_stickman(is_stickman), .is_obstacle(is_obstacle),
    .playing(playing), .dying(dying), .game_over(game_over), .flash(flash),
    .score(score), .high_score(high_score), .level(level), .speed(speed)
  );

  // Second copy scoring every frame so saturation at 9999 is reachable quickly.
  game_controller #(.SCORE_DIV(1)) dut_sat (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .is_stickman(is_stickman), .is_obstacle(is_obstacle),
    .playing(s_playing), .dying(s_dying), .game_over(s_game_over), .flash(s_flash),
    .score(s_score), .high_score(s_high_score), .level(s_level), .speed(s_speed)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  typedef enum {M_IDLE, M_PLAY, M_DYING, M_OVER} mode_e;
  mode_e m_mode;
  int    m_played;
  int    m_dticks;
  int    m_hs;
  bit    m_pend;
  bit    m_hitp;
  bit    m_key_prev;

  function automatic int score_bin(input int div);
    int v;
    v = m_played / div;
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int exp_level();
    int v;
    v = m_played / LEVEL_FRAMES;
    return (v > MAX_LEVEL) ? MAX_LEVEL : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [44:0] exp_vec();
    logic [3:0] lvl;
    logic p, d, o, f;
    lvl = 4'(exp_level());
    p = (m_mode == M_PLAY);
    d = (m_mode == M_DYING);
    o = (m_mode == M_OVER);
    f = d && (((m_dticks / 4) % 2) == 1);
    return {p, d, o, f, to_bcd(score_bin(SCORE_DIV)), to_bcd(m_hs), lvl, 5'(BASE_SPEED + exp_level())};
  endfunction

  function automatic logic [7:0] other_key();
    logic [7:0] k;
    k = 8'($urandom_range(0, 255));
    if (k == START_KEY) k = 8'h00;
    return k;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_played = 0; m_dticks = 0; m_hs = 0;
    m_pend = 0; m_hitp = 0; m_key_prev = 0;
  endtask

  // One non-tick Clk cycle with the given key and pixel flags.
  task automatic gap_cycle(input bit key_start, input bit stick, input bit obst);
    keycode = key_start ? START_KEY : other_key();
    is_stickman = stick;
    is_obstacle = obst;
    @(posedge Clk); #1;
    if (key_start && !m_key_prev) m_pend = 1;
    m_key_prev = key_start;
    if (stick && obst && m_mode == M_PLAY) m_hitp = 1;
    is_stickman = 0;
    is_obstacle = 0;
  endtask

  // Raise frame_clk; coll_now drives a collision in exactly the tick cycle.
  task automatic do_tick(input bit coll_now);
    int sc;
    frame_clk = 1;
    @(posedge Clk); #1;
    is_stickman = coll_now;
    is_obstacle = coll_now;
    @(posedge Clk); #1;
    frame_clk = 0;
    is_stickman = 0;
    is_obstacle = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (m_pend) begin m_mode = M_PLAY; m_played = 0; end
      M_PLAY: if (m_hitp || coll_now) begin m_mode = M_DYING; m_dticks = 0; end
              else m_played++;
      M_DYING: if (m_dticks == FLASH_FRAMES - 1) begin
                 m_mode = M_OVER;
                 sc = score_bin(SCORE_DIV);
                 if (sc > m_hs) m_hs = sc;
               end else m_dticks++;
      default: ;
    endcase
    m_pend = 0;
    m_hitp = 0;
  endtask

  // Frame with single-sided pixel noise (never a real collision).
  task automatic frame(input int gaps, input bit key_start);
    bit st;
    for (int g = 0; g < gaps; g++) begin
      st = 1'($urandom_range(0, 1));
      gap_cycle(key_start, st, st ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    do_tick(0);
  endtask

  task automatic test_reset();
    Reset = 1; keycode = 8'h00; frame_clk = 0; model_reset();
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (playing !== 1'b0) $display("FAIL reset_playing got %0b want 0", playing); else passes++;
    checks++; if (score !== 16'h0000) $display("FAIL reset_score got %h want 0000", score); else passes++;
    checks++; if (high_score !== 16'h0000) $display("FAIL reset_high got %h want 0000", high_score); else passes++;
    checks++; if (speed !== 5'd2) $display("FAIL reset_speed got %0d want 2", speed); else passes++;
    checks++; if ({dying, game_over, flash, level} !== 7'd0) $display("FAIL reset_flags got %b want 0", {dying, game_over, flash, level}); else passes++;
    Reset = 0;
    gap_cycle(0, 0, 0);
    do_tick(0);
    checks++; if (playing !== 1'b0) $display("FAIL idle_no_press got %0b want 0", playing); else passes++;
  endtask

  task automatic test_start();
    frame(2, 1);
    checks++; if ({playing, score, speed} !== {1'b1, 16'h0000, 5'd2}) $display("FAIL start_enter got %b/%h/%0d want 1/0000/2", playing, score, speed); else passes++;
    for (int i = 0; i < 9; i++) frame(2, 1);
    checks++; if ({playing, dying, game_over, flash, score, high_score, level, speed} !== exp_vec()) $display("FAIL start_held got %h want %h", {playing, dying, game_over, flash, score, high_score, level, speed}, exp_vec()); else passes++;
    checks++; if (score !== 16'h0001) $display("FAIL start_single got %h want 0001", score); else passes++;
    gap_cycle(0, 0, 0);
  endtask

  task automatic test_score_level();
    for (int i = 0; i < 100 && m_played < 60; i++) frame(1, 0);
    checks++; if ({score, level} !== {16'h0010, 4'd0}) $display("FAIL score_60 got %h/%0d want 0010/0", score, level); else passes++;
    for (int i = 0; i < 700 && m_played < 600; i++) frame(1, 0);
    checks++; if ({level, speed} !== {4'd1, 5'd3}) $display("FAIL level_600 got %0d/%0d want 1/3", level, speed); else passes++;
    checks++; if (score !== to_bcd(score_bin(SCORE_DIV))) $display("FAIL score_600 got %h want %h", score, to_bcd(score_bin(SCORE_DIV))); else passes++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12000 && m_played < 9999; i++) frame(1, 0);
    checks++; if (s_score !== 16'h9999) $display("FAIL sat_reach got %h want 9999", s_score); else passes++;
    checks++; if ({level, speed} !== {4'(MAX_LEVEL), 5'(BASE_SPEED + MAX_LEVEL)}) $display("FAIL level_sat got %0d/%0d want 7/9", level, speed); else passes++;
    repeat (6) frame(1, 0);
    checks++; if (s_score !== 16'h9999) $display("FAIL sat_hold got %h want 9999", s_score); else passes++;
    checks++; if (score !== to_bcd(score_bin(SCORE_DIV))) $display("FAIL score_main got %h want %h", score, to_bcd(score_bin(SCORE_DIV))); else passes++;
  endtask

  task automatic test_collision_dying();
    logic [15:0] frozen;
    frozen = score;
    gap_cycle(0, 1, 1);
    gap_cycle(0, 0, 0);
    do_tick(0);
    checks++; if ({playing, dying, score} !== {1'b0, 1'b1, frozen}) $display("FAIL hit_mid got %b/%b/%h want 0/1/%h", playing, dying, score, frozen); else passes++;
    for (int k = 1; k <= FLASH_FRAMES; k++) begin
      if (k == 10) begin gap_cycle(1, 0, 0); gap_cycle(0, 0, 0); end
      frame(1, 0);
      checks++; if ({dying, game_over, flash} !== exp_vec()[43:41]) $display("FAIL dying_tick%0d got %b want %b", k, {dying, game_over, flash}, exp_vec()[43:41]); else passes++;
    end
    checks++; if ({game_over, high_score, score} !== {1'b1, frozen, frozen}) $display("FAIL over_high got %b/%h/%h want 1/%h/%h", game_over, high_score, score, frozen, frozen); else passes++;
    repeat (3) frame(1, 0);
    checks++; if ({game_over, playing} !== 2'b10) $display("FAIL over_hold got %b want 10", {game_over, playing}); else passes++;
    gap_cycle(1, 0, 0);
    gap_cycle(0, 0, 0);
    do_tick(0);
    checks++; if ({playing, game_over, score, high_score} !== {2'b10, 16'h0000, frozen}) $display("FAIL restart got %b/%b/%h/%h want 1/0/0000/%h", playing, game_over, score, high_score, frozen); else passes++;
  endtask

  task automatic test_tick_collision();
    repeat (10) frame(1, 0);
    gap_cycle(0, 0, 0);
    do_tick(1);
    checks++; if ({playing, dying} !== 2'b01) $display("FAIL tick_hit got %b want 01", {playing, dying}); else passes++;
    repeat (FLASH_FRAMES) frame(1, 0);
    checks++; if ({playing, dying, game_over, flash, score, high_score, level, speed} !== exp_vec()) $display("FAIL tick_over got %h want %h", {playing, dying, game_over, flash, score, high_score, level, speed}, exp_vec()); else passes++;
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < 5 && m_mode != M_PLAY; i++) begin
      gap_cycle(1, 0, 0);
      gap_cycle(0, 0, 0);
      do_tick(0);
    end
    repeat (20) frame(1, 0);
    checks++; if ({playing, score} !== {1'b1, to_bcd(score_bin(SCORE_DIV))}) $display("FAIL pre_reset got %b/%h want 1/%h", playing, score, to_bcd(score_bin(SCORE_DIV))); else passes++;
    @(posedge Clk);
    #3 Reset = 1;
    #1;
    checks++; if ({playing, dying, game_over, flash} !== 4'b0000) $display("FAIL async_flags got %b want 0000", {playing, dying, game_over, flash}); else passes++;
    checks++; if ({score, high_score, level, speed} !== {32'h0, 4'd0, 5'd2}) $display("FAIL async_vals got %h/%h/%0d/%0d want 0000/0000/0/2", score, high_score, level, speed); else passes++;
    @(posedge Clk); #1;
    Reset = 0;
    model_reset();
    gap_cycle(0, 0, 0);
  endtask

  task automatic test_random();
    int gaps;
    for (int f = 0; f < 400; f++) begin
      gaps = $urandom_range(1, 4);
      for (int g = 0; g < gaps; g++) begin
        if ($urandom_range(0, 29) == 0) gap_cycle($urandom_range(0, 5) == 0, 1, 1);
        else gap_cycle($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 0);
      end
      do_tick($urandom_range(0, 29) == 0);
      checks++; if ({playing, dying, game_over, flash, score, high_score, level, speed} !== exp_vec()) $display("FAIL rand_f%0d got %h want %h", f, {playing, dying, game_over, flash, score, high_score, level, speed}, exp_vec()); else passes++;
      checks++; if (s_score !== to_bcd(score_bin(1))) $display("FAIL rand_sat_f%0d got %h want %h", f, s_score, to_bcd(score_bin(1))); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score_level();
    test_saturation();
    test_collision_dying();
    test_tick_collision();
    test_reset_mid_play();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
